player_session_ctrl: RTL and testbench

- Parametrised per-player session controller for the multi-player snake game. It replaces hard-wired per-snake start/grace logic and compile-time player gating.
- Latches which players are active at game start and runs a per-player lifecycle: idle, grace period, normal play, dead.
- Gates each player's direction inputs to a clean one-hot move and declares game over and the winner.
- Sits between the userInput instances and the snakeHead/gameSpace instances. Clocked by the game tick.

---
 rtl/player_session_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_player_session_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/player_session_ctrl.sv
// rtl/player_session_ctrl.sv - per-player session lifecycle, move gating and game-over/winner logic
module player_session_ctrl #(
  parameter int PLAYERS     = 3,
  parameter int GRACE_MOVES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PLAYERS-1:0]     player_enable,
  input  logic [4*PLAYERS-1:0]   dir_in,
  input  logic [PLAYERS-1:0]     dead_in,
  output logic [4*PLAYERS-1:0]   dir_out,
  output logic [PLAYERS-1:0]     grace,
  output logic [PLAYERS-1:0]     alive,
  output logic [PLAYERS-1:0]     active,
  output logic                   playing,
  output logic                   game_over,
  output logic [PLAYERS-1:0]     winner
);

  typedef enum logic [1:0] {G_WAIT, G_RUN, G_OVER} gstate_e;
  typedef enum logic [1:0] {P_IDLE, P_GRACE, P_NORMAL, P_DEAD} pstate_e;

  // Move count that ends the grace period; 0 means players start directly in NORMAL.
  localparam logic [3:0] GRACE_LIMIT = 4'(GRACE_MOVES);

  gstate_e            gstate_q, gstate_d;
  pstate_e            pstate_q [PLAYERS];
  pstate_e            pstate_d [PLAYERS];
  logic [3:0]         cnt_q    [PLAYERS];
  logic [3:0]         cnt_d    [PLAYERS];
  logic [PLAYERS-1:0] active_q, active_d;
  logic [PLAYERS-1:0] winner_q, winner_d;
  logic [PLAYERS-1:0] grace_q, alive_q;
  logic [PLAYERS-1:0] grace_d, alive_d;
  logic               playing_q, game_over_q;
  logic [3:0]         alive_cnt;
  logic [3:0]         active_cnt;
  logic [3:0]         cnt_inc;
  logic               last_standing;

  function automatic logic [3:0] popcount(input logic [PLAYERS-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < PLAYERS; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

  // Next-state for global and per-player FSMs; the game-over decision looks at next-state survivors.
  always_comb begin
    gstate_d      = gstate_q;
    active_d      = active_q;
    winner_d      = winner_q;
    alive_d       = '0;
    grace_d       = '0;
    cnt_inc       = 4'd0;
    alive_cnt     = 4'd0;
    active_cnt    = popcount(active_q);
    last_standing = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      pstate_d[p] = pstate_q[p];
      cnt_d[p]    = cnt_q[p];
    end

    case (gstate_q)
      G_WAIT: begin
        if (start && (player_enable != '0)) begin
          gstate_d = G_RUN;
          active_d = player_enable;
          for (int p = 0; p < PLAYERS; p++) begin
            cnt_d[p] = 4'd0;
            if (player_enable[p]) begin
              pstate_d[p] = (GRACE_MOVES == 0) ? P_NORMAL : P_GRACE;
            end
          end
        end
      end
      G_RUN: begin
        for (int p = 0; p < PLAYERS; p++) begin
          case (pstate_q[p])
            P_GRACE: begin
              // Self-overlap while growing is expected, so deaths are ignored here.
              if (|dir_in[4*p +: 4]) begin
                cnt_inc  = (cnt_q[p] == 4'd15) ? 4'd15 : cnt_q[p] + 4'd1;
                cnt_d[p] = cnt_inc;
                if (cnt_inc >= GRACE_LIMIT) begin
                  pstate_d[p] = P_NORMAL;
                end
              end
            end
            P_NORMAL: begin
              if (dead_in[p]) begin
                pstate_d[p] = P_DEAD;
              end
            end
            default: begin
            end
          endcase
        end
      end
      default: begin
      end
    endcase

    for (int p = 0; p < PLAYERS; p++) begin
      alive_d[p] = (pstate_d[p] == P_GRACE) || (pstate_d[p] == P_NORMAL);
      grace_d[p] = (pstate_d[p] == P_GRACE);
    end
    alive_cnt = popcount(alive_d);

    // A solo game ends when its player dies; a multi-player game ends with one or no survivor.
    if (active_cnt == 4'd1) begin
      last_standing = (alive_cnt == 4'd0);
    end else begin
      last_standing = (alive_cnt <= 4'd1);
    end

    if ((gstate_q == G_RUN) && last_standing) begin
      gstate_d = G_OVER;
      winner_d = alive_d;
    end
  end

  // State and registered status outputs; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      gstate_q    <= G_WAIT;
      active_q    <= '0;
      winner_q    <= '0;
      grace_q     <= '0;
      alive_q     <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      for (int p = 0; p < PLAYERS; p++) begin
        pstate_q[p] <= P_IDLE;
        cnt_q[p]    <= 4'd0;
      end
    end else begin
      gstate_q    <= gstate_d;
      active_q    <= active_d;
      winner_q    <= winner_d;
      grace_q     <= grace_d;
      alive_q     <= alive_d;
      playing_q   <= (gstate_d == G_RUN);
      game_over_q <= (gstate_d == G_OVER);
      for (int p = 0; p < PLAYERS; p++) begin
        pstate_q[p] <= pstate_d[p];
        cnt_q[p]    <= cnt_d[p];
      end
    end
  end

  // Zero-latency move gating: one-hot with priority left > right > up > down.
  always_comb begin
    dir_out = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      if ((gstate_q == G_RUN) &&
          ((pstate_q[p] == P_GRACE) || (pstate_q[p] == P_NORMAL))) begin
        if (dir_in[4*p])
          dir_out[4*p +: 4] = 4'b0001;
        else if (dir_in[4*p+1])
          dir_out[4*p +: 4] = 4'b0010;
        else if (dir_in[4*p+2])
          dir_out[4*p +: 4] = 4'b0100;
        else if (dir_in[4*p+3])
          dir_out[4*p +: 4] = 4'b1000;
      end
    end
  end

  assign grace     = grace_q;
  assign alive     = alive_q;
  assign active    = active_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_player_session_ctrl.sv
// tb/tb_player_session_ctrl.sv - table-driven bench for player_session_ctrl (3 players, 3 grace moves)
module tb_player_session_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  player_enable;
  logic [11:0] dir_in;
  logic [2:0]  dead_in;
  logic [11:0] dir_out;
  logic [2:0]  grace;
  logic [2:0]  alive;
  logic [2:0]  active;
  logic        playing;
  logic        game_over;
  logic [2:0]  winner;

  int tests_run;
  int tests_failed;
  int cur_vec;

  typedef struct {
    logic        rst;
    logic        st;
    logic [2:0]  en;
    logic [11:0] dir;
    logic [2:0]  dead;
    logic [11:0] exp_dir;
    logic [2:0]  exp_grace;
    logic [2:0]  exp_alive;
    logic [2:0]  exp_active;
    logic        exp_play;
    logic        exp_over;
    logic [2:0]  exp_win;
  } vec_t;

  vec_t vecs[$];

  player_session_ctrl #(.PLAYERS(3), .GRACE_MOVES(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .player_enable (player_enable),
    .dir_in        (dir_in),
    .dead_in       (dead_in),
    .dir_out       (dir_out),
    .grace         (grace),
    .alive         (alive),
    .active        (active),
    .playing       (playing),
    .game_over     (game_over),
    .winner        (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL v%0d %s: got %0h expected %0h", cur_vec, name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic st, input logic [2:0] en,
                     input logic [11:0] dir, input logic [2:0] dead,
                     input logic [11:0] edir, input logic [2:0] eg, input logic [2:0] ea,
                     input logic [2:0] eact, input logic ep, input logic eo,
                     input logic [2:0] ew);
    vec_t v;
    v.rst = rst; v.st = st; v.en = en; v.dir = dir; v.dead = dead;
    v.exp_dir = edir; v.exp_grace = eg; v.exp_alive = ea; v.exp_active = eact;
    v.exp_play = ep; v.exp_over = eo; v.exp_win = ew;
    vecs.push_back(v);
  endtask

  task automatic check_regs(input logic [2:0] eg, input logic [2:0] ea, input logic [2:0] eact,
                            input logic ep, input logic eo, input logic [2:0] ew);
    check("grace", 32'(grace), 32'(eg));
    check("alive", 32'(alive), 32'(ea));
    check("active", 32'(active), 32'(eact));
    check("playing", 32'(playing), 32'(ep));
    check("game_over", 32'(game_over), 32'(eo));
    check("winner", 32'(winner), 32'(ew));
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset = v.rst; start = v.st; player_enable = v.en; dir_in = v.dir; dead_in = v.dead;
    #1;
    check("dir_out", 32'(dir_out), 32'(v.exp_dir));
    @(posedge clk);
    #1;
    check_regs(v.exp_grace, v.exp_alive, v.exp_active, v.exp_play, v.exp_over, v.exp_win);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; cur_vec = -1;
    reset = 1'b1; start = 1'b0; player_enable = '0; dir_in = '0; dead_in = '0;

    //   rst st  en      dir      dead    exp_dir  grace   alive   active  pl over win
    // Start with players 0 and 2; player 1 is gated even with all directions high.
    add(0, 1, 3'b101, 12'h000, 3'b000, 12'h000, 3'b101, 3'b101, 3'b101, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h0F1, 3'b000, 12'h001, 3'b101, 3'b101, 3'b101, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h000, 3'b001, 12'h000, 3'b101, 3'b101, 3'b101, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h001, 3'b000, 12'h001, 3'b101, 3'b101, 3'b101, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h001, 3'b000, 12'h001, 3'b100, 3'b101, 3'b101, 1, 0, 3'b000);
    // Priority: p0 {up,right} -> right, p2 {down,up} -> up.
    add(0, 0, 3'b000, 12'hC06, 3'b000, 12'h402, 3'b100, 3'b101, 3'b101, 1, 0, 3'b000);
    // p0 dies in NORMAL; p2 (still in grace) is the last one alive.
    add(0, 0, 3'b000, 12'h000, 3'b001, 12'h000, 3'b100, 3'b100, 3'b101, 0, 1, 3'b100);
    // OVER is sticky and frozen; start/deaths/directions ignored.
    add(0, 1, 3'b011, 12'hFFF, 3'b111, 12'h000, 3'b100, 3'b100, 3'b101, 0, 1, 3'b100);
    // Reset in OVER, then start with no players stays in WAIT.
    add(1, 1, 3'b111, 12'h000, 3'b000, 12'h000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000);
    add(0, 1, 3'b000, 12'h000, 3'b000, 12'h000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000);
    // Three players through grace, then two die together.
    add(0, 1, 3'b111, 12'h000, 3'b000, 12'h000, 3'b111, 3'b111, 3'b111, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h111, 3'b000, 12'h111, 3'b111, 3'b111, 3'b111, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h111, 3'b000, 12'h111, 3'b111, 3'b111, 3'b111, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h111, 3'b000, 12'h111, 3'b000, 3'b111, 3'b111, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h248, 3'b011, 12'h248, 3'b000, 3'b100, 3'b111, 0, 1, 3'b100);
    add(0, 0, 3'b000, 12'hFFF, 3'b000, 12'h000, 3'b000, 3'b100, 3'b111, 0, 1, 3'b100);
    add(1, 0, 3'b000, 12'h000, 3'b000, 12'h000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000);
    // Solo game: priority in NORMAL, then death gives OVER with no winner.
    add(0, 1, 3'b001, 12'h000, 3'b000, 12'h000, 3'b001, 3'b001, 3'b001, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h001, 3'b000, 12'h001, 3'b001, 3'b001, 3'b001, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h001, 3'b000, 12'h001, 3'b001, 3'b001, 3'b001, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h001, 3'b000, 12'h001, 3'b000, 3'b001, 3'b001, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h006, 3'b000, 12'h002, 3'b000, 3'b001, 3'b001, 1, 0, 3'b000);
    add(0, 0, 3'b000, 12'h000, 3'b001, 12'h000, 3'b000, 3'b000, 3'b001, 0, 1, 3'b000);
    add(1, 0, 3'b000, 12'h000, 3'b000, 12'h000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000);
    // Reset mid-RUN overrides deaths and directions on the same edge.
    add(0, 1, 3'b110, 12'h000, 3'b000, 12'h000, 3'b110, 3'b110, 3'b110, 1, 0, 3'b000);
    add(1, 1, 3'b111, 12'h0F0, 3'b110, 12'h010, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_dir_out", 32'(dir_out), 32'h0);
    check_regs(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      cur_vec = i;
      apply(vecs[i]);
    end

    // Two players die on the same edge: game over with no winner; grace ignores deaths.
    cur_vec = 100;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; player_enable = 3'b011; dir_in = '0; dead_in = '0;
    @(posedge clk); #1;
    check("h4_active", 32'(active), 32'h3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0; player_enable = '0; dir_in = 12'h011; dead_in = 3'b011;
      @(posedge clk); #1;
      check("h4_alive_grace", 32'(alive), 32'h3);
    end
    check("h4_grace_done", 32'(grace), 32'h0);
    check("h4_playing", 32'(playing), 32'h1);
    @(negedge clk);
    dir_in = '0; dead_in = 3'b011;
    @(posedge clk); #1;
    check("h4_game_over", 32'(game_over), 32'h1);
    check("h4_winner", 32'(winner), 32'h0);
    check("h4_alive", 32'(alive), 32'h0);
    check("h4_playing_off", 32'(playing), 32'h0);
    @(negedge clk);
    dead_in = '0; dir_in = 12'h111;
    #1;
    check("h4_dir_over", 32'(dir_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
